// File: rtl/joy_serializer.sv
// joy_serializer
//   Responder end of the serial joystick link. Emulates the parallel-load
//   shift-register chain of the joystick adapter: two 6-button joystick states
//   are captured while joy_load_n is low and shifted out LSB-first on joy_data
//   on each rising edge of joy_clk.
//
//   Frame order (serial index 0 first):
//     0..5   joy1 {up,down,left,right,fire1,fire2}
//     6,7    FILL_BIT
//     8..13  joy2, same order
//     14..   FILL_BIT
//
// Ports:
//   clk          system clock
//   reset_n      synchronous active-low reset
//   joy1_n[5:0]  joystick 1, active low {fire2,fire1,right,left,down,up}
//   joy2_n[5:0]  joystick 2, same layout
//   joy_clk      shift clock from decoder (asynchronous to clk)
//   joy_load_n   parallel load from decoder, active low (asynchronous)
//   joy_data     serial data to decoder
//   frame_done   one-cycle pulse when CHAIN_BITS bits have been shifted
//   short_frame  one-cycle pulse when a load interrupts a partial frame
//
// Optional feature macro: JOYSER_DEBOUNCE_EN
//   Defined   : each parallel input is debounced over DEBOUNCE_CYCLES samples.
//   Undefined : each parallel input passes through one register stage.

module joy_serializer #(
  parameter int unsigned CHAIN_BITS      = 16,
  parameter logic        FILL_BIT        = 1'b1,
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] joy1_n,
  input  logic [5:0] joy2_n,
  input  logic       joy_clk,
  input  logic       joy_load_n,
  output logic       joy_data,
  output logic       frame_done,
  output logic       short_frame
);

  localparam int unsigned CW = $clog2(CHAIN_BITS + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  // Synchronizers reset to 1 (clock high, load inactive) so that leaving
  // reset never produces a spurious shift edge or load.
  logic clk_s1_q, clk_s2_q, clk_s3_q;
  logic load_s1_q, load_s2_q;
  logic clk_rise;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clk_s1_q  <= 1'b1;
      clk_s2_q  <= 1'b1;
      clk_s3_q  <= 1'b1;
      load_s1_q <= 1'b1;
      load_s2_q <= 1'b1;
    end else begin
      clk_s1_q  <= joy_clk;
      clk_s2_q  <= clk_s1_q;
      clk_s3_q  <= clk_s2_q;
      load_s1_q <= joy_load_n;
      load_s2_q <= load_s1_q;
    end
  end

  assign clk_rise = clk_s2_q & ~clk_s3_q;

  // Parallel input conditioning; cap holds {joy2_n, joy1_n} as seen by LOAD.
  logic [11:0] raw;
  logic [11:0] cap;

  assign raw = {joy2_n, joy1_n};

`ifdef JOYSER_DEBOUNCE_EN
  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [11:0]   pend_q, pend_d;
  logic [11:0]   stab_q, stab_d;
  logic [DW-1:0] dcnt_q [12];
  logic [DW-1:0] dcnt_d [12];

  // dcnt counts consecutive samples equal to pend (the first differing
  // sample counts as one); stab follows pend once the count is reached.
  always_comb begin
    pend_d = pend_q;
    stab_d = stab_q;
    dcnt_d = dcnt_q;
    for (int unsigned i = 0; i < 12; i++) begin
      if (raw[i] != pend_q[i]) begin
        pend_d[i] = raw[i];
        dcnt_d[i] = DW'(1);
      end else if (dcnt_q[i] != DW'(DEBOUNCE_CYCLES)) begin
        dcnt_d[i] = dcnt_q[i] + DW'(1);
      end
      if (dcnt_d[i] == DW'(DEBOUNCE_CYCLES)) stab_d[i] = pend_d[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pend_q <= '1;
      stab_q <= '1;
      for (int unsigned i = 0; i < 12; i++) dcnt_q[i] <= '0;
    end else begin
      pend_q <= pend_d;
      stab_q <= stab_d;
      for (int unsigned i = 0; i < 12; i++) dcnt_q[i] <= dcnt_d[i];
    end
  end

  assign cap = stab_q;
`else
  logic [11:0] in_q;

  always_ff @(posedge clk) begin
    if (!reset_n) in_q <= '1;
    else          in_q <= raw;
  end

  assign cap = in_q;
`endif

  // Parallel image of the chain as the adapter's shift registers would hold it.
  logic [CHAIN_BITS-1:0] sr_load;

  always_comb begin
    sr_load = {CHAIN_BITS{FILL_BIT}};
    for (int unsigned i = 0; i < 6; i++) begin
      sr_load[i] = cap[i];
      if (8 + i < CHAIN_BITS) sr_load[8+i] = cap[6+i];
    end
  end

  state_t                state_q, state_d;
  logic [CHAIN_BITS-1:0] sr_q, sr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  fd_q, fd_d;
  logic                  sf_q, sf_d;
  logic [CHAIN_BITS-1:0] sr_shift;

  assign sr_shift = {FILL_BIT, sr_q[CHAIN_BITS-1:1]};

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    fd_d    = 1'b0;
    sf_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!load_s2_q) begin
          state_d = LOAD;
          sr_d    = sr_load;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        sr_d  = sr_load;
        cnt_d = '0;
        if (load_s2_q) state_d = SHIFT;
      end
      SHIFT: begin
        // The completing edge takes priority over a coincident load so the
        // frame is reported done; the load is then taken from DONE.
        if (clk_rise && cnt_q == CW'(CHAIN_BITS - 1)) begin
          sr_d    = sr_shift;
          cnt_d   = CW'(CHAIN_BITS);
          fd_d    = 1'b1;
          state_d = DONE;
        end else if (!load_s2_q) begin
          state_d = LOAD;
          sr_d    = sr_load;
          cnt_d   = '0;
          sf_d    = (cnt_q != '0);
        end else if (clk_rise) begin
          sr_d  = sr_shift;
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (!load_s2_q) begin
          state_d = LOAD;
          sr_d    = sr_load;
          cnt_d   = '0;
        end else if (clk_rise) begin
          sr_d = sr_shift;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sr_q    <= {CHAIN_BITS{FILL_BIT}};
      cnt_q   <= '0;
      fd_q    <= 1'b0;
      sf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      fd_q    <= fd_d;
      sf_q    <= sf_d;
    end
  end

  assign joy_data    = sr_q[0];
  assign frame_done  = fd_q;
  assign short_frame = sf_q;

endmodule

// File: doc/joy_serializer.md
Name: joy_serializer

Overview:
- Responder end of the serial joystick link: emulates the parallel-load shift-register chain on the joystick adapter.
- Captures two 6-button joystick states in parallel and shifts them out on joy_data, driven by joy_load_n and joy_clk from the existing joydecoder.
- Used in simulation benches and in the loopback/board-bring-up build, where it stands in for the adapter hardware.

Parameters:
- CHAIN_BITS, 16, total bit positions in one frame; legal range 12..32.
- FILL_BIT, 1'b1, value presented for unused positions and after the chain is exhausted.
- DEBOUNCE_CYCLES, 1000, stability window in clk cycles for each parallel input (only with JOYSER_DEBOUNCE_EN).

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- reset_n  in  1  synchronous active-low reset.
- joy1_n  in  6  joystick 1, active low: {fire2,fire1,right,left,down,up}.
- joy2_n  in  6  joystick 2, same layout.
- joy_clk  in  1  shift clock from decoder; asynchronous to clk.
- joy_load_n  in  1  parallel load from decoder, active low; asynchronous to clk.
- joy_data  out  1  serial data to decoder.
- frame_done  out  1  one-cycle pulse when all CHAIN_BITS bits have been shifted.
- short_frame  out  1  one-cycle pulse when a load arrives before the previous frame completed.

Behaviour:
- Input sync: joy_clk and joy_load_n each pass through a 2-flop synchronizer. The flop after it is used for rising-edge detect of joy_clk.
- Frame order, serial index 0 first:
  - 0..5 = joy1 up, down, left, right, fire1, fire2.
  - 6, 7 = FILL_BIT.
  - 8..13 = joy2 in the same order.
  - 14..CHAIN_BITS-1 = FILL_BIT.
- Shift register sr[CHAIN_BITS-1:0]; joy_data = sr[0] (registered).
- Each shift: sr <= {FILL_BIT, sr[CHAIN_BITS-1:1]}.
- Shift counter cnt, width clog2(CHAIN_BITS+1), saturates at CHAIN_BITS.
- State machine:
  - IDLE: after reset. joy_data = FILL_BIT; shift edges ignored. Synced load low -> LOAD.
  - LOAD: sr reloaded every cycle from the current inputs (transparent, like a 74HC165), cnt = 0. Synced load high -> SHIFT.
  - SHIFT: on each synced joy_clk rising edge, shift and increment cnt. When cnt reaches CHAIN_BITS: pulse frame_done, go to DONE. Synced load low -> LOAD; if cnt != 0, pulse short_frame.
  - DONE: further edges shift in FILL_BIT, so joy_data = FILL_BIT. Synced load low -> LOAD with no short_frame.
- Latency:
  - Pin edge of joy_clk to joy_data change: 3 clk cycles (2 sync + 1 register).
  - Load-low pin to joy_data = bit 0: 3 clk cycles.
- Simultaneous events:
  - joy_clk edge while synced load is low: load wins, no shift, cnt stays 0.
  - Load going low in the same cycle as the final edge: frame_done fires, load is taken next cycle, no short_frame.
- Load without any intervening shift (cnt = 0): no short_frame.
- Reset values, applied synchronously on any cycle including mid-frame:
  - state = IDLE, sr = all FILL_BIT, cnt = 0.
  - joy_data = FILL_BIT, frame_done = 0, short_frame = 0.
  - Synchronizer flops reset to 1 (load inactive, clk high), so no spurious edge after reset.
- Minimum supported joy_clk high and low times: 3 clk cycles each; narrower pulses may be missed (not flagged).

Optional Feature:
- Macro: JOYSER_DEBOUNCE_EN.
- Defined:
  - Each of the 12 parallel inputs feeds its own debouncer with a counter of width clog2(DEBOUNCE_CYCLES+1).
  - The counter restarts whenever the raw input differs from its pending value.
  - The stable value updates only after DEBOUNCE_CYCLES consecutive equal samples.
  - LOAD captures the stable values; stable values reset to 1.
- Undefined: raw inputs pass through one register stage; LOAD captures those registered values.

Test Plan:
- Reset, then joy_load_n held high with 20 joy_clk pulses -> joy_data stays 1 throughout; frame_done and short_frame never pulse.
- joy1_n=6'b111110 (up), joy2_n=6'b011111 (fire2), load then 16 clk pulses -> serial stream idx0=0, idx13=0, all other bits 1; frame_done pulses once, 3 cycles after the 16th edge.
- Change joy1_n to 6'b101111 (fire1) while load is held low -> joy_data reflects new bit 0 = 1; bit 4 shifted out = 0 after release.
- Load, 5 clk pulses, load again -> short_frame pulses exactly once; next 16-bit frame is correct.
- 20 clk pulses after a full frame -> bits 16..19 = 1; no second frame_done.
- Assert reset_n low mid-frame after 7 shifts -> next cycle joy_data = 1, state IDLE; with JOYSER_DEBOUNCE_EN and DEBOUNCE_CYCLES=8, a 5-cycle glitch on joy1 up is not captured, while an input held 8 cycles is.
